med_window_feeder: RTL
======================

Name: med_window_feeder

Overview:
- Upstream stage of the median filter.
- Accepts an 8-bit raster pixel stream and keeps the two previous image lines in line buffers.
- For every interior pixel, it serialises the 3x3 neighbourhood as 9 bytes on DI/DSI, which the median block consumes.
- It then stalls until the median block signals completion on DSO, and only then accepts further pixels.

Parameters:
- WIDTH, 640, pixels per line (>=3)
- HEIGHT, 480, lines per frame (>=3)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- PIX_IN  in  8  incoming pixel, raster order
- PIX_VLD  in  1  PIX_IN valid
- PIX_RDY  out  1  feeder can accept a pixel this cycle
- DI  out  8  window byte to median block
- DSI  out  1  high for exactly 9 consecutive cycles per window
- DSO  in  1  median result valid pulse from median block (end of window processing)
- FRAME_DONE  out  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. On RST: state=ACCEPT, row=0, col=0, DI=0, DSI=0, FRAME_DONE=0, window registers=0. Line buffer contents are not cleared; rows 0-1 never emit windows, so stale data is unobservable.
- FSM states: ACCEPT, SEND, WAIT.
- PIX_RDY=1 iff state==ACCEPT (combinational from state). A pixel is accepted when PIX_VLD & PIX_RDY.
- On accept at (row,col):
  - New column = {lb1[col], lb0[col], PIX_IN}, top to bottom.
  - The 3x3 window shifts left by one column and the new column is inserted at the right.
  - Write lb1[col]<=lb0[col] and lb0[col]<=PIX_IN.
  - col increments. At WIDTH-1, col wraps to 0 and row increments. At (HEIGHT-1, WIDTH-1), row and col wrap to 0 and FRAME_DONE pulses on the next cycle.
- Window emission: if the accepted pixel has row>=2 and col>=2, next state=SEND; otherwise remain in ACCEPT.
- SEND lasts 9 cycles, starting the cycle after accept. DSI=1 throughout.
  - DI order (window centred at row-1,col-1): (r-2,c-2),(r-2,c-1),(r-2,c),(r-1,c-2),(r-1,c-1),(r-1,c),(r,c-2),(r,c-1),(r,c).
  - A 4-bit counter 0..8 selects the byte. After count 8, go to WAIT with DSI=0.
- WAIT: hold until DSO=1, then go to ACCEPT next cycle. DSO is ignored in ACCEPT and SEND.
- DI and DSI are registered. DI holds its last value when DSI=0.
- Output count: (WIDTH-2)*(HEIGHT-2) windows per frame. Border pixels produce no window.
- Throughput: at most one window per (1 + 9 + median latency) cycles. Non-emitting pixels are accepted at one per cycle.
- Gaps in PIX_VLD simply stall the counters; there is no timeout.
- RST during SEND/WAIT aborts immediately: DSI drops asynchronously to 0 and the next frame starts at (0,0).

Decomposition:
- Package med_pkg:
  - typedef pixel_t (logic [7:0])
  - enum feeder_state_t {ACCEPT, SEND, WAIT}
  - constant NB_WIN=9
- Sub-module med_line_buffer:
  - WIDTH x 8 synchronous RAM, one read and one write at the same address per accept (read-before-write).
  - Instantiated twice (lb0, lb1).
- Estimated RTL: ~200 lines top plus ~40 lines line buffer.

Test Plan:
- 4x4 frame, pixel=16*row+col, DSO returned 35 cycles after each DSI fall:
  - Exactly 4 windows.
  - First DI sequence 0,1,2,16,17,18,32,33,34.
  - Last window 17,18,19,33,34,35,49,50,51.
  - FRAME_DONE one pulse after pixel 15.
- Handshake: PIX_VLD held high during SEND/WAIT -> PIX_RDY=0, no pixel consumed. Accept resumes the cycle after DSO.
- Spurious DSO asserted during ACCEPT and mid-SEND -> ignored, still 9 DSI cycles, then waits for a real DSO in WAIT.
- PIX_VLD toggling 1/0 every cycle on 5x3 frame -> 3 windows, centre bytes 17,18,19 (pixel=16*row+col), identical to gap-free run.
- RST asserted at 5th SEND cycle -> DSI=0 immediately, PIX_RDY=1 after release. A new 4x4 frame yields the same 4 windows as the first test.
- Back-to-back frames (2x 4x4) -> 8 windows, second-frame windows unaffected by first-frame line-buffer contents.

Source files
------------

// File: rtl/med_pkg.sv
// Shared types and constants for the median filter front end.
package med_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        ACCEPT,
        SEND,
        WAIT
    } feeder_state_t;

    // Bytes per 3x3 window handed to the median block.
    localparam int NB_WIN = 9;

endpackage

// File: rtl/med_line_buffer.sv
// One image line of pixel storage. Writes are clocked; the read is combinational so the
// previous line's value at the same column is available in the accept cycle (read-before-write).
module med_line_buffer
    import med_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int ADDR_W = $clog2(WIDTH)
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data
);

    pixel_t mem [WIDTH];

    assign rd_data = mem[addr];

    // NOTE: the storage array has no reset; a reset would turn it into flops and rows 0-1
    // overwrite every entry before any window can read it.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/med_window_feeder.sv
// Raster pixel stream to 3x3 window serialiser: emits 9 bytes on DI/DSI per interior pixel,
// then stalls the stream until the median block answers on DSO.
module med_window_feeder
    import med_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] PIX_IN,
    input  logic       PIX_VLD,
    output logic       PIX_RDY,
    output logic [7:0] DI,
    output logic       DSI,
    input  logic       DSO,
    output logic       FRAME_DONE
);

    localparam int               COL_W    = $clog2(WIDTH);
    localparam int               ROW_W    = $clog2(HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [3:0]       CNT_LAST = 4'(NB_WIN - 1);

    feeder_state_t    state;
    feeder_state_t    state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [3:0]       cnt;
    pixel_t           win [NB_WIN];
    pixel_t           lb0_q;
    pixel_t           lb1_q;
    pixel_t           next_byte;
    logic             accept;
    logic             emit;
    logic             last_pix;

    assign accept   = PIX_VLD && (state == ACCEPT);
    assign emit     = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

    // lb0 holds the previous line, lb1 the line before it.
    med_line_buffer #(.WIDTH(WIDTH), .ADDR_W(COL_W)) lb0 (
        .CLK     (CLK),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (PIX_IN),
        .rd_data (lb0_q)
    );

    med_line_buffer #(.WIDTH(WIDTH), .ADDR_W(COL_W)) lb1 (
        .CLK     (CLK),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (lb0_q),
        .rd_data (lb1_q)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        PIX_RDY   = 1'b0;
        case (state)
            ACCEPT: begin
                PIX_RDY = 1'b1;
                if (emit) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (DSO) begin
                    state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // cnt indexes the byte currently on DI, so the register loads the following one.
    always_comb begin
        next_byte = win[0];
        for (int i = 0; i < NB_WIN - 1; i++) begin
            if (cnt == 4'(i)) begin
                next_byte = win[i + 1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row        <= '0;
            col        <= '0;
            cnt        <= '0;
            DI         <= '0;
            DSI        <= 1'b0;
            FRAME_DONE <= 1'b0;
            for (int i = 0; i < NB_WIN; i++) begin
                win[i] <= '0;
            end
        end else begin
            FRAME_DONE <= accept && last_pix;

            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[3*r]     <= win[3*r + 1];
                    win[3*r + 1] <= win[3*r + 2];
                end
                win[2] <= lb1_q;
                win[5] <= lb0_q;
                win[8] <= PIX_IN;

                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            // Top-left byte of the shifted window is the old top-middle byte.
            if (emit) begin
                DI  <= win[1];
                DSI <= 1'b1;
                cnt <= '0;
            end else if (state == SEND) begin
                if (cnt == CNT_LAST) begin
                    DSI <= 1'b0;
                end else begin
                    DI  <= next_byte;
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule
